// File: rtl/temp_pkg.sv
// rtl/temp_pkg.sv - shared types and constants for the temperature statistics block
//
// Purpose: common data width and FSM state encoding used by temp_stats and
//          temp_minmax.
// Contents:
//   TEMP_W  width of a signed Celsius sample
//   fsm_t   sample pipeline states (WAIT, CAPTURE, ACCUM, PUBLISH)
package temp_pkg;

  localparam int TEMP_W = 8;

  typedef enum logic [1:0] {
    WAIT    = 2'd0,
    CAPTURE = 2'd1,
    ACCUM   = 2'd2,
    PUBLISH = 2'd3
  } fsm_t;

endpackage

// File: rtl/temp_minmax.sv
// rtl/temp_minmax.sv - signed running minimum/maximum tracker
//
// Purpose: holds the minimum and maximum sample seen since reset or the last
//          clear. The first sample after a clear loads both registers.
// Ports:
//   clk      in   clock
//   rst      in   asynchronous active-high reset
//   clear    in   synchronous clear of the tracker (wins over load_en)
//   load_en  in   accept 'sample' this cycle
//   sample   in   signed sample value
//   min_val  out  signed minimum since reset/clear (0 when empty)
//   max_val  out  signed maximum since reset/clear (0 when empty)
module temp_minmax
  import temp_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     load_en,
  input  logic signed [TEMP_W-1:0] sample,
  output logic signed [TEMP_W-1:0] min_val,
  output logic signed [TEMP_W-1:0] max_val
);

  logic has_sample;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      has_sample <= 1'b0;
      min_val    <= '0;
      max_val    <= '0;
    end else if (clear) begin
      has_sample <= 1'b0;
      min_val    <= '0;
      max_val    <= '0;
    end else if (load_en) begin
      if (!has_sample) begin
        // The zeroed registers are not real samples, so never compare against them.
        has_sample <= 1'b1;
        min_val    <= sample;
        max_val    <= sample;
      end else begin
        if (sample < min_val) min_val <= sample;
        if (sample > max_val) max_val <= sample;
      end
    end
  end

endmodule

// File: rtl/temp_stats.sv
// rtl/temp_stats.sv - periodic temperature sampler with moving average, min/max and alarm
//
// Purpose: every SAMPLE_DIV clocks captures temp_data into a 2^LOG2_WIN deep
//          circular window, maintains a running sum, and publishes the floor
//          average, min/max since clear and a hysteretic over-temperature flag.
// Ports:
//   clk_200KHz   in   block clock
//   reset        in   asynchronous active-high reset
//   temp_data    in   signed degC sample source, may change at any time
//   clear_stats  in   synchronous clear of window, average, min/max and alarm
//   avg_data     out  signed floor(sum / 2^LOG2_WIN), 0 until window is full
//   min_data     out  signed minimum since reset/clear
//   max_data     out  signed maximum since reset/clear
//   avg_valid    out  window is full and avg_data is meaningful
//   sample_stb   out  one-cycle pulse on the cycle the outputs update
//   over_temp    out  alarm: sets at avg >= T_HIGH, clears at avg <= T_LOW
module temp_stats
  import temp_pkg::*;
#(
  parameter int SAMPLE_DIV = 40000,
  parameter int LOG2_WIN   = 3,
  parameter int T_HIGH     = 30,
  parameter int T_LOW      = 28
) (
  input  logic              clk_200KHz,
  input  logic              reset,
  input  logic [TEMP_W-1:0] temp_data,
  input  logic              clear_stats,
  output logic [TEMP_W-1:0] avg_data,
  output logic [TEMP_W-1:0] min_data,
  output logic [TEMP_W-1:0] max_data,
  output logic              avg_valid,
  output logic              sample_stb,
  output logic              over_temp
);

  localparam int WIN    = 1 << LOG2_WIN;
  localparam int CNT_W  = $clog2(SAMPLE_DIV);
  localparam int SUM_W  = TEMP_W + LOG2_WIN;
  localparam int FILL_W = LOG2_WIN + 1;

  localparam logic signed [TEMP_W-1:0] T_HIGH_V = TEMP_W'(T_HIGH);
  localparam logic signed [TEMP_W-1:0] T_LOW_V  = TEMP_W'(T_LOW);

  // Sample timebase: free-running, untouched by clear_stats.
  logic [CNT_W-1:0] cnt;
  logic             tc;

  assign tc = (cnt == CNT_W'(SAMPLE_DIV - 1));

  always_ff @(posedge clk_200KHz or posedge reset) begin
    if (reset)   cnt <= '0;
    else if (tc) cnt <= '0;
    else         cnt <= cnt + CNT_W'(1);
  end

  // Pipeline FSM
  fsm_t state, next_state;

  always_ff @(posedge clk_200KHz or posedge reset) begin
    if (reset) state <= WAIT;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      WAIT:    if (tc) next_state = CAPTURE;
      CAPTURE: next_state = ACCUM;
      ACCUM:   next_state = PUBLISH;
      PUBLISH: next_state = WAIT;
      default: next_state = WAIT;
    endcase
    // A clear abandons any sample in flight, including one latched this cycle.
    if (clear_stats) next_state = WAIT;
  end

  // Window storage and running sum
  logic signed [TEMP_W-1:0] win_buf [WIN];
  logic signed [TEMP_W-1:0] new_s;
  logic signed [TEMP_W-1:0] old_s;
  logic [LOG2_WIN-1:0]      wr_ptr;
  logic [FILL_W-1:0]        fill;
  logic signed [SUM_W-1:0]  sum;

  logic                     win_full;
  logic signed [TEMP_W-1:0] avg_next;
  logic                     over_next;
  logic signed [TEMP_W-1:0] mm_min;
  logic signed [TEMP_W-1:0] mm_max;

  assign win_full = (fill == FILL_W'(WIN));
  // The average of 8-bit samples always fits back into 8 bits.
  assign avg_next = TEMP_W'(sum >>> LOG2_WIN);

  always_comb begin
    over_next = over_temp;
    if (!win_full)                over_next = 1'b0;
    else if (avg_next >= T_HIGH_V) over_next = 1'b1;
    else if (avg_next <= T_LOW_V)  over_next = 1'b0;
  end

  always_ff @(posedge clk_200KHz or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < WIN; i++) win_buf[i] <= '0;
      new_s      <= '0;
      old_s      <= '0;
      wr_ptr     <= '0;
      fill       <= '0;
      sum        <= '0;
      avg_data   <= '0;
      min_data   <= '0;
      max_data   <= '0;
      avg_valid  <= 1'b0;
      sample_stb <= 1'b0;
      over_temp  <= 1'b0;
    end else if (clear_stats) begin
      for (int i = 0; i < WIN; i++) win_buf[i] <= '0;
      wr_ptr     <= '0;
      fill       <= '0;
      sum        <= '0;
      avg_data   <= '0;
      min_data   <= '0;
      max_data   <= '0;
      avg_valid  <= 1'b0;
      sample_stb <= 1'b0;
      over_temp  <= 1'b0;
    end else begin
      sample_stb <= 1'b0;
      case (state)
        WAIT: begin
          if (tc) new_s <= temp_data;
        end
        CAPTURE: begin
          old_s           <= win_buf[wr_ptr];
          win_buf[wr_ptr] <= new_s;
        end
        ACCUM: begin
          // Subtracting the evicted slot keeps the sum exact across wrap-around;
          // empty slots are zero so the fill phase needs no special case.
          sum    <= sum + {{LOG2_WIN{new_s[TEMP_W-1]}}, new_s}
                        - {{LOG2_WIN{old_s[TEMP_W-1]}}, old_s};
          wr_ptr <= wr_ptr + LOG2_WIN'(1);
          if (!win_full) fill <= fill + FILL_W'(1);
        end
        PUBLISH: begin
          sample_stb <= 1'b1;
          if (win_full) begin
            avg_valid <= 1'b1;
            avg_data  <= avg_next;
          end
          min_data  <= mm_min;
          max_data  <= mm_max;
          over_temp <= over_next;
        end
        default: ;
      endcase
    end
  end

  temp_minmax u_minmax (
    .clk     (clk_200KHz),
    .rst     (reset),
    .clear   (clear_stats),
    .load_en (state == ACCUM),
    .sample  (new_s),
    .min_val (mm_min),
    .max_val (mm_max)
  );

endmodule
